// File: rtl/vga_capture_rx_pkg.sv
// Shared types and constants for the VGA capture receiver: FSM states,
// default window timing and the BT.601-style luma weights.
package vga_capture_rx_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_V_BLANK = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int DEF_COLS  = 512;
  localparam int DEF_ROWS  = 512;
  localparam int DEF_H_BP  = 88;
  localparam int DEF_V_BP  = 23;
  localparam int DEF_CNT_W = 11;

  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  // Weights sum to 256, so a grey input maps back to itself.
  function automatic logic [7:0] luma8(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
    logic [15:0] acc;
    acc = LUMA_R * {8'd0, r} + LUMA_G * {8'd0, g} + LUMA_B * {8'd0, b};
    return acc[15:8];
  endfunction

endpackage

// File: rtl/vga_capture_rx_if.sv
// VGA video input and captured pixel stream of the capture receiver.
// master = VGA source side, slave = capture receiver.
interface vga_capture_rx_if;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       HS;
  logic       VS;
  logic [7:0] out_pixel;
  logic       out_pixel_valid;
  logic       out_sof;
  logic       out_eol;
  logic       frame_done;
  logic       frame_err;

  modport master (
    output R, G, B, HS, VS,
    input  out_pixel, out_pixel_valid, out_sof, out_eol, frame_done, frame_err
  );

  modport slave (
    input  R, G, B, HS, VS,
    output out_pixel, out_pixel_valid, out_sof, out_eol, frame_done, frame_err
  );
endinterface

// File: rtl/vga_capture_rx_sync_edge.sv
// Two-stage HS/VS register with rising-edge pulses (previous 0, current 1).
// Both stages reset to 1 so no edge is seen until a sync actually goes low.
module vga_capture_rx_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic hs,
  input  logic vs,
  output logic hs_rise,
  output logic vs_rise
);

  logic hs1_r, hs2_r, vs1_r, vs2_r;

  // sync stage 1 and stage 2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_r <= 1'b1;
      hs2_r <= 1'b1;
      vs1_r <= 1'b1;
      vs2_r <= 1'b1;
    end else begin
      hs1_r <= hs;
      hs2_r <= hs1_r;
      vs1_r <= vs;
      vs2_r <= vs1_r;
    end
  end

  assign hs_rise = hs1_r & ~hs2_r;
  assign vs_rise = vs1_r & ~vs2_r;

endmodule

// File: rtl/vga_capture_rx.sv
// VGA capture receiver: recovers position from sync edges, extracts the
// COLS x ROWS window and emits it as a raster byte stream.
// Optional luma conversion: define VGA_CAPTURE_LUMA_EN.
module vga_capture_rx
  import vga_capture_rx_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int H_BP  = DEF_H_BP,
  parameter int V_BP  = DEF_V_BP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_capture_rx_if.slave  bus
);

  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(H_BP + COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] VBP_M1   = (V_BP == 0) ? '0 : CNT_W'(V_BP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam cap_state_e       FIRST_ST = (V_BP == 0) ? ST_ACTIVE : ST_V_BLANK;

  logic             hs_rise, vs_rise;
  logic [7:0]       r1_r, r2_r;
  logic [CNT_W-1:0] h_cnt_r, v_cnt_r, row_r, row_s;
  logic             line_open_r, line_open_s;
  cap_state_e       state_r, state_s;
  logic             take_s, sof_s, eol_s, done_s, err_s, in_win_s, last_col_s;
  logic [7:0]       pix_s;
  logic [7:0]       pix_a_r;
  logic             valid_a_r, sof_a_r, eol_a_r, done_a_r, err_a_r;

  vga_capture_rx_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .hs      (bus.HS),
    .vs      (bus.VS),
    .hs_rise (hs_rise),
    .vs_rise (vs_rise)
  );

  // colour pipeline: stage 2 lines up with h_cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_r <= 8'd0;
      r2_r <= 8'd0;
    end else begin
      r1_r <= bus.R;
      r2_r <= r1_r;
    end
  end

`ifdef VGA_CAPTURE_LUMA_EN
  logic [7:0] g1_r, g2_r, b1_r, b2_r;

  // green/blue pipeline for luma
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1_r <= 8'd0;
      g2_r <= 8'd0;
      b1_r <= 8'd0;
      b2_r <= 8'd0;
    end else begin
      g1_r <= bus.G;
      g2_r <= g1_r;
      b1_r <= bus.B;
      b2_r <= b1_r;
    end
  end
`endif

  // position counters; a VS edge wins over a coincident HS edge for v_cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else begin
      if (hs_rise) begin
        h_cnt_r <= '0;
      end else if (h_cnt_r != CNT_MAX) begin
        h_cnt_r <= h_cnt_r + CNT_W'(1);
      end
      if (vs_rise) begin
        v_cnt_r <= '0;
      end else if (hs_rise && (v_cnt_r != CNT_MAX)) begin
        v_cnt_r <= v_cnt_r + CNT_W'(1);
      end
    end
  end

  // FSM state and line tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_WAIT_VS;
      row_r       <= '0;
      line_open_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      row_r       <= row_s;
      line_open_r <= line_open_s;
    end
  end

  assign in_win_s   = (h_cnt_r >= WIN_LO) && (h_cnt_r <= WIN_LAST);
  assign last_col_s = (h_cnt_r == WIN_LAST);

  // next state, pixel take and marker decode
  always_comb begin
    state_s     = state_r;
    row_s       = row_r;
    line_open_s = line_open_r;
    take_s      = 1'b0;
    sof_s       = 1'b0;
    eol_s       = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_WAIT_VS, ST_DONE: begin
        if (vs_rise) begin
          state_s     = FIRST_ST;
          row_s       = '0;
          line_open_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_V_BLANK: begin
        if (vs_rise) begin
          state_s     = FIRST_ST;
          row_s       = '0;
          line_open_s = 1'b0;
        end else if (hs_rise && (V_BP != 0) && (v_cnt_r == VBP_M1)) begin
          state_s     = ST_ACTIVE;
          row_s       = '0;
          line_open_s = 1'b1;
        end else begin
          state_s = ST_V_BLANK;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          err_s       = 1'b1;
          state_s     = FIRST_ST;
          row_s       = '0;
          line_open_s = 1'b0;
        end else if (hs_rise) begin
          // a line still open here never delivered its last pixel
          err_s       = line_open_r;
          line_open_s = 1'b1;
        end else if (line_open_r && in_win_s) begin
          take_s = 1'b1;
          sof_s  = (row_r == '0) && (h_cnt_r == WIN_LO);
          if (last_col_s) begin
            eol_s       = 1'b1;
            line_open_s = 1'b0;
            row_s       = row_r + CNT_W'(1);
            if (row_r == ROW_LAST) begin
              done_s  = 1'b1;
              state_s = ST_DONE;
            end else begin
              state_s = ST_ACTIVE;
            end
          end else begin
            line_open_s = 1'b1;
          end
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      default: begin
        state_s     = ST_WAIT_VS;
        row_s       = '0;
        line_open_s = 1'b0;
      end
    endcase
  end

`ifdef VGA_CAPTURE_LUMA_EN
  assign pix_s = take_s ? luma8(r2_r, g2_r, b2_r) : 8'd0;
`else
  assign pix_s = take_s ? r2_r : 8'd0;
`endif

  // first output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_a_r   <= 8'd0;
      valid_a_r <= 1'b0;
      sof_a_r   <= 1'b0;
      eol_a_r   <= 1'b0;
      done_a_r  <= 1'b0;
      err_a_r   <= 1'b0;
    end else begin
      pix_a_r   <= pix_s;
      valid_a_r <= take_s;
      sof_a_r   <= sof_s;
      eol_a_r   <= eol_s;
      done_a_r  <= done_s;
      err_a_r   <= err_s;
    end
  end

`ifdef VGA_CAPTURE_LUMA_EN
  logic [7:0] pix_b_r;
  logic       valid_b_r, sof_b_r, eol_b_r, done_b_r, err_b_r;

  // extra stage keeps all markers aligned with the luma pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_b_r   <= 8'd0;
      valid_b_r <= 1'b0;
      sof_b_r   <= 1'b0;
      eol_b_r   <= 1'b0;
      done_b_r  <= 1'b0;
      err_b_r   <= 1'b0;
    end else begin
      pix_b_r   <= pix_a_r;
      valid_b_r <= valid_a_r;
      sof_b_r   <= sof_a_r;
      eol_b_r   <= eol_a_r;
      done_b_r  <= done_a_r;
      err_b_r   <= err_a_r;
    end
  end

  assign bus.out_pixel       = pix_b_r;
  assign bus.out_pixel_valid = valid_b_r;
  assign bus.out_sof         = sof_b_r;
  assign bus.out_eol         = eol_b_r;
  assign bus.frame_done      = done_b_r;
  assign bus.frame_err       = err_b_r;
`else
  assign bus.out_pixel       = pix_a_r;
  assign bus.out_pixel_valid = valid_a_r;
  assign bus.out_sof         = sof_a_r;
  assign bus.out_eol         = eol_a_r;
  assign bus.frame_done      = done_a_r;
  assign bus.frame_err       = err_a_r;
`endif

endmodule

// File: tb/tb_vga_capture_rx.sv
// Directed bench for vga_capture_rx on a 4x3 window (H_BP=2, V_BP=1).
// Define VGA_CAPTURE_LUMA_EN to also exercise the luma build.
module tb_vga_capture_rx;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int H_BP = 2;
  localparam int V_BP = 1;
`ifdef VGA_CAPTURE_LUMA_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_capture_rx_if bus ();

  vga_capture_rx #(.COLS(COLS), .ROWS(ROWS), .H_BP(H_BP), .V_BP(V_BP), .CNT_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int n_err = 0;
  int n_done = 0;
  int sof_cyc = -1;
  int px0_cyc = 0;
  int t_in = 0;
  bit red_only = 1'b0;

  logic [7:0] cap_pix[$];
  bit         cap_sof[$], cap_eol[$], cap_done[$];
  logic [7:0] exp_pix[$];
  bit         exp_sof[$], exp_eol[$], exp_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  // capture every output event, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_pixel_valid) begin
        cap_pix.push_back(bus.out_pixel);
        cap_sof.push_back(bus.out_sof);
        cap_eol.push_back(bus.out_eol);
        cap_done.push_back(bus.frame_done);
        if (bus.out_sof && sof_cyc < 0) sof_cyc <= cyc;
      end
      if (bus.frame_err) n_err <= n_err + 1;
      if (bus.frame_done) n_done <= n_done + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic hs, input logic vs, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    bus.HS = hs;
    bus.VS = vs;
    bus.R  = r;
    bus.G  = g;
    bus.B  = b;
  endtask

  task automatic line(input logic [7:0] base, input int step, input int npix,
                      input int hi_len, input int nlow);
    logic [7:0] d;
    for (int i = 0; i < nlow; i++) drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    for (int j = 0; j < hi_len; j++) begin
      d = (j >= H_BP && j < H_BP + npix) ? 8'(int'(base) + step * (j - H_BP)) : 8'd0;
      drive(1'b1, 1'b1, d, red_only ? 8'd0 : d, red_only ? 8'd0 : d);
      if (j == H_BP) px0_cyc = cyc;
    end
  endtask

  task automatic vsync();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) line(8'd0, 0, 0, 10, 2);
  endtask

  task automatic exp_line(input logic [7:0] base, input int step, input int n,
                          input bit first, input bit eol, input bit last);
    for (int c = 0; c < n; c++) begin
      exp_pix.push_back(8'(int'(base) + step * c));
      exp_sof.push_back(first && c == 0);
      exp_eol.push_back(eol && c == n - 1);
      exp_done.push_back(last && c == n - 1);
    end
  endtask

  task automatic clear_all();
    cap_pix.delete(); cap_sof.delete(); cap_eol.delete(); cap_done.delete();
    exp_pix.delete(); exp_sof.delete(); exp_eol.delete(); exp_done.delete();
    n_err = 0;
    n_done = 0;
    sof_cyc = -1;
  endtask

  task automatic check_caps(input string tag, input int want_err, input int want_done);
    int n;
    chk({tag, "_count"}, cap_pix.size(), exp_pix.size());
    n = (cap_pix.size() < exp_pix.size()) ? cap_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_pix%0d", tag, i), cap_pix[i], exp_pix[i]);
      chk($sformatf("%s_sof%0d", tag, i), cap_sof[i], exp_sof[i]);
      chk($sformatf("%s_eol%0d", tag, i), cap_eol[i], exp_eol[i]);
      chk($sformatf("%s_done%0d", tag, i), cap_done[i], exp_done[i]);
    end
    chk({tag, "_err"}, n_err, want_err);
    chk({tag, "_done"}, n_done, want_done);
  endtask

  task automatic check_quiet_outputs(input string tag);
    chk({tag, "_pix"}, bus.out_pixel, 8'd0);
    chk({tag, "_valid"}, bus.out_pixel_valid, 1'b0);
    chk({tag, "_sof"}, bus.out_sof, 1'b0);
    chk({tag, "_eol"}, bus.out_eol, 1'b0);
    chk({tag, "_fdone"}, bus.frame_done, 1'b0);
    chk({tag, "_ferr"}, bus.frame_err, 1'b0);
  endtask

  initial begin
    bus.HS = 1'b1; bus.VS = 1'b1; bus.R = 8'd0; bus.G = 8'd0; bus.B = 8'd0;
    repeat (3) @(negedge clk);
    check_quiet_outputs("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet_outputs("post_rst");
    clear_all();

    // small frame 01..0C plus pipeline latency
    vsync();
    line(8'h01, 1, 4, 10, 2);
    t_in = px0_cyc;
    line(8'h05, 1, 4, 10, 2);
    line(8'h09, 1, 4, 10, 2);
    blank(2);
    exp_line(8'h01, 1, 4, 1'b1, 1'b1, 1'b0);
    exp_line(8'h05, 1, 4, 1'b0, 1'b1, 1'b0);
    exp_line(8'h09, 1, 4, 1'b0, 1'b1, 1'b1);
    check_caps("t1", 0, 1);
    chk("t1_latency", sof_cyc - t_in, LAT + 1);
    clear_all();

    // short frame aborted by VS after two lines, then a full frame
    vsync();
    line(8'h11, 1, 4, 10, 2);
    line(8'h15, 1, 4, 10, 2);
    vsync();
    line(8'h21, 1, 4, 10, 2);
    line(8'h25, 1, 4, 10, 2);
    line(8'h29, 1, 4, 10, 2);
    blank(1);
    exp_line(8'h11, 1, 4, 1'b1, 1'b1, 1'b0);
    exp_line(8'h15, 1, 4, 1'b0, 1'b1, 1'b0);
    exp_line(8'h21, 1, 4, 1'b1, 1'b1, 1'b0);
    exp_line(8'h25, 1, 4, 1'b0, 1'b1, 1'b0);
    exp_line(8'h29, 1, 4, 1'b0, 1'b1, 1'b1);
    check_caps("t4", 1, 1);
    clear_all();

    // HS returns after 3 of 4 pixels: error, no eol, line not counted
    vsync();
    line(8'h51, 1, 4, 10, 2);
    line(8'h31, 1, 3, 5, 2);
    line(8'h41, 1, 4, 10, 1);
    line(8'h61, 1, 4, 10, 2);
    blank(1);
    exp_line(8'h51, 1, 4, 1'b1, 1'b1, 1'b0);
    exp_line(8'h31, 1, 3, 1'b0, 1'b0, 1'b0);
    exp_line(8'h41, 1, 4, 1'b0, 1'b1, 1'b0);
    exp_line(8'h61, 1, 4, 1'b0, 1'b1, 1'b1);
    check_caps("t5", 1, 1);
    clear_all();

    // reset in the middle of an active line
    vsync();
    line(8'h71, 1, 4, 10, 2);
    drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    for (int j = 0; j < 4; j++) drive(1'b1, 1'b1, 8'hA0 + 8'(j), 8'hA0 + 8'(j), 8'hA0 + 8'(j));
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) drive(1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
    check_quiet_outputs("t3_in_rst");
    rst_n = 1'b1;
    clear_all();
    for (int j = 0; j < 3; j++) drive(1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
    line(8'h81, 1, 4, 10, 2);
    line(8'h85, 1, 4, 10, 2);
    blank(1);
    check_caps("t3_wait", 0, 0);
    clear_all();
    vsync();
    line(8'h91, 1, 4, 10, 2);
    line(8'h95, 1, 4, 10, 2);
    line(8'h99, 1, 4, 10, 2);
    blank(1);
    exp_line(8'h91, 1, 4, 1'b1, 1'b1, 1'b0);
    exp_line(8'h95, 1, 4, 1'b0, 1'b1, 1'b0);
    exp_line(8'h99, 1, 4, 1'b0, 1'b1, 1'b1);
    check_caps("t3_next", 0, 1);
    clear_all();

`ifdef VGA_CAPTURE_LUMA_EN
    // grey 200 stays 200, pure red 255 gives 76
    vsync();
    line(8'd200, 0, 4, 10, 2);
    red_only = 1'b1;
    line(8'd255, 0, 4, 10, 2);
    line(8'd255, 0, 4, 10, 2);
    red_only = 1'b0;
    blank(1);
    exp_line(8'd200, 0, 4, 1'b1, 1'b1, 1'b0);
    exp_line(8'd76, 0, 4, 1'b0, 1'b1, 1'b0);
    exp_line(8'd76, 0, 4, 1'b0, 1'b1, 1'b1);
    check_caps("t6", 0, 1);
    clear_all();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
